// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone constants for the wb_ext arbiter.
// Imported by the arbiter top and the round-robin selector.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

  localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
  localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
  localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

  localparam logic [BTE_W-1:0] BTE_LINEAR = 2'b00;
  localparam logic [BTE_W-1:0] BTE_WRAP4  = 2'b01;
  localparam logic [BTE_W-1:0] BTE_WRAP8  = 2'b10;
  localparam logic [BTE_W-1:0] BTE_WRAP16 = 2'b11;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Combinational cyclic selector: first requester at or after ptr.
// One-hot grant, zero when nobody requests.
module arb_rr
  import wb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // Pass one covers [ptr, N-1], pass two wraps to [0, ptr-1].
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among tile wb_ext
// masters, with bus ownership held for the whole cycle and a watchdog.
module wb_ext_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS-1:0]            m_cab,
  input  logic [NUM_MASTERS*CTI_W-1:0]      m_cti,
  input  logic [NUM_MASTERS*BTE_W-1:0]      m_bte,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [NUM_MASTERS-1:0]            m_rty,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_r,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_w,
  output logic [DATA_WIDTH/8-1:0]           s_sel,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic                              s_cab,
  output logic [CTI_W-1:0]                  s_cti,
  output logic [BTE_W-1:0]                  s_bte,
  input  logic                              s_ack,
  input  logic                              s_err,
  input  logic                              s_rty,
  input  logic [DATA_WIDTH-1:0]             s_dat_r,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy,
  output logic                              timeout_evt
);

  localparam int N  = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = ptr_w(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  req, rr_gnt;
  logic          own_cyc, own_stb, stall;

  assign req = m_cyc & m_stb;

  arb_rr #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_gnt[i]) begin
        ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // grant_q is zero outside ownership, so this mux idles at zero.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_cab   = 1'b0;
    s_cti   = '0;
    s_bte   = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        s_adr   = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_w = m_dat_w[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel   = m_sel[i*SW +: SW];
        s_we    = m_we[i];
        s_cab   = m_cab[i];
        s_cti   = m_cti[i*CTI_W +: CTI_W];
        s_bte   = m_bte[i*BTE_W +: BTE_W];
        own_cyc = m_cyc[i];
        own_stb = m_stb[i];
      end
    end
  end

  assign s_cyc = (state_q == OWNED) & own_cyc;
  assign s_stb = (state_q == OWNED) & own_stb;

  assign stall = (state_q == OWNED) & own_stb
               & ~(s_ack | s_err | s_rty);

  always_comb begin
    m_ack = '0;
    m_err = '0;
    m_rty = '0;
    unique case (state_q)
      OWNED: begin
        m_ack = grant_q & {N{s_ack}};
        m_err = grant_q & {N{s_err}};
        m_rty = grant_q & {N{s_rty}};
      end
      ABORT:   m_err = grant_q;
      default: ;
    endcase
  end

  assign m_dat_r     = {N{s_dat_r}};
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_evt = (state_q == ABORT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWNED;
          grant_d = rr_gnt;
          ptr_d   = ptr_nxt;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (stall) begin
          // Abort on the edge that would bring the count to TIMEOUT.
          if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            state_d = ABORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ABORT: begin
        if (own_cyc) begin
          state_d = OWNED;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed bench for wb_ext_arbiter: arbitration order, bursts,
// error routing, watchdog abort and asynchronous reset.
module tb_wb_ext_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N*AW-1:0] m_adr   = '0;
  logic [N*DW-1:0] m_dat_w = '0;
  logic [N*SW-1:0] m_sel   = '0;
  logic [N-1:0]    m_cyc   = '0;
  logic [N-1:0]    m_stb   = '0;
  logic [N-1:0]    m_we    = '0;
  logic [N-1:0]    m_cab   = '0;
  logic [N*3-1:0]  m_cti   = '0;
  logic [N*2-1:0]  m_bte   = '0;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic [N*DW-1:0] m_dat_r;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic            s_cyc, s_stb, s_we, s_cab;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_ack = 1'b0;
  logic            s_err = 1'b0;
  logic            s_rty = 1'b0;
  logic [DW-1:0]   s_dat_r = '0;
  logic [N-1:0]    grant;
  logic            busy, timeout_evt;

  int n_chk = 0;
  int n_err = 0;

  wb_ext_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_adr       (m_adr),
    .m_dat_w     (m_dat_w),
    .m_sel       (m_sel),
    .m_cyc       (m_cyc),
    .m_stb       (m_stb),
    .m_we        (m_we),
    .m_cab       (m_cab),
    .m_cti       (m_cti),
    .m_bte       (m_bte),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_rty       (m_rty),
    .m_dat_r     (m_dat_r),
    .s_adr       (s_adr),
    .s_dat_w     (s_dat_w),
    .s_sel       (s_sel),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_cab       (s_cab),
    .s_cti       (s_cti),
    .s_bte       (s_bte),
    .s_ack       (s_ack),
    .s_err       (s_err),
    .s_rty       (s_rty),
    .s_dat_r     (s_dat_r),
    .grant       (grant),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic on);
    m_cyc[i] = on;
    m_stb[i] = on;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_tevt", timeout_evt, 0);
    step();
    rst = 1'b1;

    // Masters 0 and 2 together, pointer at 0
    m_adr[0*AW +: AW] = 32'h1000;
    m_adr[2*AW +: AW] = 32'h3000;
    req(0, 1'b1);
    req(2, 1'b1);
    @(negedge clk);
    chk("t1_latency", grant, 0);
    step();
    s_ack   = 1'b1;
    s_dat_r = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_grant0", grant, 4'b0001);
    chk("t1_sadr0", s_adr, 32'h1000);
    chk("t1_ack0", m_ack, 4'b0001);
    chk("t1_bcast", m_dat_r[2*DW +: DW], 32'hDEAD_BEEF);
    step();
    s_ack = 1'b0;
    req(0, 1'b0);
    step();
    @(negedge clk);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_scyc", s_cyc, 0);
    chk("t1_idle_busy", busy, 0);
    step();
    @(negedge clk);
    chk("t1_grant2", grant, 4'b0100);
    chk("t1_sadr2", s_adr, 32'h3000);
    step();
    req(2, 1'b0);
    step();

    // Burst by master 1 while master 3 waits; pointer at 3
    req(1, 1'b1);
    m_cti[1*3 +: 3] = 3'b010;
    step();
    req(3, 1'b1);
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti[1*3 +: 3] = 3'b111;
      @(negedge clk);
      chk("t2_burst_grant", grant, 4'b0010);
      chk("t2_burst_ack", m_ack, 4'b0010);
      chk("t2_burst_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
      step();
    end
    s_ack = 1'b0;
    req(1, 1'b0);
    @(negedge clk);
    chk("t2_hold_grant", grant, 4'b0010);
    chk("t2_no_ack", m_ack, 0);
    step();
    @(negedge clk);
    chk("t2_idle", grant, 0);
    step();
    @(negedge clk);
    chk("t2_grant3", grant, 4'b1000);

    // Slave error routed to owner only
    s_err = 1'b1;
    @(negedge clk);
    chk("t3_err", m_err, 4'b1000);
    chk("t3_err_ack", m_ack, 0);
    step();
    s_err = 1'b0;
    @(negedge clk);
    chk("t3_keep_grant", grant, 4'b1000);
    chk("t3_err_clear", m_err, 0);
    req(3, 1'b0);
    step();
    step();

    // Watchdog: slave never answers, TIMEOUT = 8
    req(0, 1'b1);
    step();
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("t4_stall_tevt", timeout_evt, 0);
      chk("t4_stall_scyc", s_cyc, 1);
      step();
    end
    @(negedge clk);
    chk("t4_stall8_tevt", timeout_evt, 0);
    step();
    s_ack = 1'b1;
    @(negedge clk);
    chk("t4_abort_tevt", timeout_evt, 1);
    chk("t4_abort_err", m_err, 4'b0001);
    chk("t4_abort_scyc", s_cyc, 0);
    chk("t4_abort_sstb", s_stb, 0);
    chk("t4_abort_busy", busy, 1);
    chk("t4_abort_drop_ack", m_ack, 0);
    step();
    s_ack = 1'b0;
    @(negedge clk);
    chk("t4_back_tevt", timeout_evt, 0);
    chk("t4_back_scyc", s_cyc, 1);
    chk("t4_back_grant", grant, 4'b0001);
    req(0, 1'b0);
    step();
    step();

    // Asynchronous reset while owned; pointer at 1
    req(2, 1'b1);
    step();
    @(negedge clk);
    chk("t5_grant", grant, 4'b0100);
    chk("t5_sstb", s_stb, 1);
    #2;
    rst   = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("t5_rst_scyc", s_cyc, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ack", m_ack, 0);
    req(2, 1'b0);
    s_ack = 1'b0;
    step();
    step();
    rst = 1'b1;

    // All four request continuously; pointer restarts at 0
    for (int i = 0; i < N; i++) req(i, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      s_ack = 1'b1;
      @(negedge clk);
      chk("t6_rr_grant", grant, 4'b0001 << (k % 4));
      chk("t6_rr_ack", m_ack, 4'b0001 << (k % 4));
      step();
      s_ack = 1'b0;
      req(k % 4, 1'b0);
      step();
      @(negedge clk);
      chk("t6_gap_busy", busy, 0);
      req(k % 4, 1'b1);
      step();
    end
    m_cyc = '0;
    m_stb = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
